// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// controller states and the divide-by-zero quotient fill value.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

    // Every quotient bit is set when dividing by zero; replicated to WIDTH.
    localparam logic DIV0_QUOT_FILL = 1'b1;

    function automatic logic op_is_signed(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    function automatic logic op_is_div(input mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_negate.sv
// Combinational conditional two's-complement negate: val_o = neg_i ? -val_i : val_i.
module mdu_negate #(
    parameter int W = 32
) (
    input  logic         neg_i,
    input  logic [W-1:0] val_i,
    output logic [W-1:0] val_o
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    always_comb begin
        val_o = val_i;
        if (neg_i) begin
            val_o = (~val_i) + ONE;
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One shift-add or restoring-subtract step per cycle; WIDTH+1 cycles per op.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    mdu_state_e           state_q, state_d;
    mdu_op_e              op_q, op_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic                 neg_q, neg_d;
    logic                 rneg_q, rneg_d;
    logic                 div0_q, div0_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    mdu_op_e              op_in;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       div_diff;
    logic                 div_ok;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;

    assign op_in = mdu_op_e'(op);
    assign a_neg = op_is_signed(op_in) & a[WIDTH-1];
    assign b_neg = op_is_signed(op_in) & b[WIDTH-1];

    mdu_negate #(.W(WIDTH)) u_abs_a (
        .neg_i (a_neg),
        .val_i (a),
        .val_o (abs_a)
    );

    mdu_negate #(.W(WIDTH)) u_abs_b (
        .neg_i (b_neg),
        .val_i (b),
        .val_o (abs_b)
    );

    // Multiply step: acc = {partial product, remaining multiplier bits}.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, dvs_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide step: acc = {remainder, dividend/quotient}; bit WIDTH of the
    // trial difference is the borrow since the shifted remainder < 2*divisor.
    assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff = rem_sh - {1'b0, dvs_q};
    assign div_ok   = ~div_diff[WIDTH];
    assign div_next = {(div_ok ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                       acc_q[WIDTH-2:0], div_ok};

    mdu_negate #(.W(2*WIDTH)) u_fix_prod (
        .neg_i (neg_q),
        .val_i (acc_q),
        .val_o (prod_fix)
    );

    mdu_negate #(.W(WIDTH)) u_fix_quot (
        .neg_i (neg_q),
        .val_i (acc_q[WIDTH-1:0]),
        .val_o (quot_fix)
    );

    mdu_negate #(.W(WIDTH)) u_fix_rem (
        .neg_i (rneg_q),
        .val_i (acc_q[2*WIDTH-1:WIDTH]),
        .val_o (rem_fix)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dvs_d   = dvs_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        div0_d  = div0_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = done_q;

        if (ena) begin
            done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                        op_d    = op_in;
                        cnt_d   = '0;
                        neg_d   = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        div0_d  = op_is_div(op_in) && (b == '0);
                        if (op_is_div(op_in)) begin
                            acc_d = {{WIDTH{1'b0}}, abs_a};
                            dvs_d = abs_b;
                        end else begin
                            acc_d = {{WIDTH{1'b0}}, abs_b};
                            dvs_d = abs_a;
                        end
                    end else begin
                        if (hi_we) begin
                            hi_d = wdata;
                        end
                        if (lo_we) begin
                            lo_d = wdata;
                        end
                    end
                end
                RUN: begin
                    acc_d = op_is_div(op_q) ? div_next : mul_next;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    if (op_is_div(op_q)) begin
                        hi_d = rem_fix;
                        lo_d = div0_q ? {WIDTH{DIV0_QUOT_FILL}} : quot_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= MDU_MULT;
            cnt_q   <= '0;
            acc_q   <= '0;
            dvs_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            div0_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            div0_q  <= div0_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter (WIDTH=32): vector table plus hand-built
// sequences for busy-side drops, enable stalls and mid-operation reset.
module tb_mdu_iter;
    import mdu_pkg::*;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    mdu_iter #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation and wait for done. inj_at: cycle after E0 at which a
    // stray start+lo_we is driven; gap_at/gap_len: window with ena low.
    task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input int inj_at, input int gap_at, input int gap_len,
                          output int lat, output logic busy0, output logic [31:0] lo0,
                          output logic [31:0] lo_mid);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        tick();
        start = 1'b0;
        lo_we = 1'b0;
        hi_we = 1'b0;
        a     = '0;
        b     = '0;
        busy0 = busy;
        lo0   = lo;
        lo_mid = lo;
        lat   = 0;
        while (lat < 200) begin
            if (lat == inj_at) begin
                start = 1'b1;
                op    = MDU_DIVU;
                a     = 32'd1;
                b     = 32'd1;
                lo_we = 1'b1;
                wdata = 32'h0000_BEEF;
            end
            if (lat == gap_at) ena = 1'b0;
            if (lat == gap_at + gap_len) ena = 1'b1;
            tick();
            start = 1'b0;
            lo_we = 1'b0;
            lat++;
            if (lat == inj_at + 1) lo_mid = lo;
            if (done) break;
        end
        if (!done) lat = -1;
    endtask

    initial begin
        int          lat;
        int          done_cnt;
        logic        busy0;
        logic [31:0] lo0;
        logic [31:0] lo_mid;

        vecs[0]  = '{MDU_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1]  = '{MDU_MULTU, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2]  = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4]  = '{MDU_DIVU,  32'd10,        32'd0,         32'h0000_000A, 32'hFFFF_FFFF};
        vecs[5]  = '{MDU_MULT,  32'd7,         32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6};
        vecs[6]  = '{MDU_MULTU, 32'h1234_5678, 32'h10,        32'h0000_0001, 32'h2345_6780};
        vecs[7]  = '{MDU_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E};
        vecs[8]  = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[9]  = '{MDU_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[10] = '{MDU_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[11] = '{MDU_DIVU,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF};
        vecs[12] = '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

        rst = 1'b0; ena = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) tick();
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        rst = 1'b1;
        tick();

        hi_we = 1'b1; wdata = 32'h0000_1234;
        tick();
        hi_we = 1'b0;
        check("mthi", hi, 32'h0000_1234);
        $display("MTHI wdata=%h hi=%h", 32'h1234, hi);
        lo_we = 1'b1; wdata = 32'h0000_5678;
        tick();
        lo_we = 1'b0;
        check("mtlo", lo, 32'h0000_5678);
        check("mtlo_hi_kept", hi, 32'h0000_1234);
        $display("MTLO wdata=%h lo=%h", 32'h5678, lo);

        lo_we = 1'b1; wdata = 32'h0000_DEAD;
        run_op(MDU_MULTU, 32'd3, 32'd4, -1, -1, 0, lat, busy0, lo0, lo_mid);
        check("start_lowe_busy", {31'd0, busy0}, 32'd1);
        check("start_lowe_dropped", lo0, 32'h0000_5678);
        check("start_lowe_lat", 32'(lat), 32'd33);
        check("start_lowe_hi", hi, 32'd0);
        check("start_lowe_lo", lo, 32'd12);
        $display("MULTU+lo_we lat=%0d hi=%h lo=%h", lat, hi, lo);

        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 5, -1, 0, lat, busy0, lo0, lo_mid);
        check("busy_lowe_dropped", lo_mid, 32'd12);
        check("busy_start_lat", 32'(lat), 32'd33);
        check("busy_start_hi", hi, 32'h0000_0001);
        check("busy_start_lo", lo, 32'hFFFF_FFFE);
        tick();
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("no_queued_start", {31'd0, busy}, 32'd0);
        $display("MULTU busy-side lat=%0d hi=%h lo=%h", lat, hi, lo);

        run_op(MDU_MULT, 32'hFFFF_FFFD, 32'd5, -1, 10, 5, lat, busy0, lo0, lo_mid);
        check("ena_gap_lat", 32'(lat), 32'd38);
        check("ena_gap_hi", hi, 32'hFFFF_FFFF);
        check("ena_gap_lo", lo, 32'hFFFF_FFF1);
        $display("MULT ena-gap lat=%0d hi=%h lo=%h", lat, hi, lo);

        // Back-to-back: each vector starts in the done cycle of the previous one.
        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, -1, 0, lat, busy0, lo0, lo_mid);
            check($sformatf("vec%0d_busy", i), {31'd0, busy0}, 32'd1);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'd33);
            check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
            $display("vec%0d op=%0d a=%h b=%h lat=%0d hi=%h lo=%h",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, lat, hi, lo);
        end

        start = 1'b1; op = MDU_DIV; a = 32'hFFFF_FFF9; b = 32'd2;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        tick();
        rst = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) done_cnt++;
        end
        check("rst_mid_no_done", 32'(done_cnt), 32'd0);
        check("rst_mid_idle", {31'd0, busy}, 32'd0);
        $display("DIV reset mid-run busy=%0d hi=%h lo=%h done_pulses=%0d", busy, hi, lo, done_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
